// File: rtl/bullet_arbiter.sv
// Bullet slot arbiter: shares a pool of bullet slots between the player
// tank (requester 0) and the enemy tanks. One grant per cycle, round-robin
// among eligible requesters, lowest free slot allocated. Each requester has
// a frame-tick cooldown after a grant and a cap on its live bullets.
// The slot-free input is named slot_release because "release" is a
// reserved word in SystemVerilog.
module bullet_arbiter #(
  parameter int NREQ     = 4,
  parameter int NSLOT    = 8,
  parameter int COOLDOWN = 8,
  parameter int MAX_LIVE = 2
) (
  input  logic                            clk_100mhz,
  input  logic                            RSTN,
  input  logic                            enable,
  input  logic                            frame_tick,
  input  logic [NREQ-1:0]                 req,
  input  logic [NSLOT-1:0]                slot_release,
  output logic [NREQ-1:0]                 grant,
  output logic                            grant_valid,
  output logic [$clog2(NSLOT)-1:0]        grant_slot,
  output logic [NSLOT-1:0]                slot_busy,
  output logic [NSLOT*$clog2(NREQ)-1:0]   slot_owner,
  output logic [$clog2(NSLOT+1)-1:0]      busy_count
);

  localparam int OW   = $clog2(NREQ);
  localparam int SW   = $clog2(NSLOT);
  localparam int CNTW = $clog2(NSLOT+1);
  // COOLDOWN=0 would give a zero-width counter; keep one bit that stays 0.
  localparam int CW   = (COOLDOWN > 0) ? $clog2(COOLDOWN+1) : 1;
  localparam int LW   = $clog2(MAX_LIVE+1);

  logic [CW-1:0]         cooldown     [NREQ];
  logic [LW-1:0]         live         [NREQ];
  logic [OW-1:0]         rr_ptr;

  logic                  any_free;
  logic [SW-1:0]         free_idx;
  logic [NREQ-1:0]       elig;
  logic                  win_found;
  logic [OW-1:0]         win_idx;
  logic [NREQ-1:0]       grant_nxt;
  logic [NSLOT-1:0]      busy_nxt;
  logic [NSLOT*OW-1:0]   owner_nxt;
  logic [CNTW-1:0]       cnt_nxt;
  logic [CW-1:0]         cooldown_nxt [NREQ];
  logic [LW-1:0]         live_nxt     [NREQ];

  // Lowest free slot in the registered bitmap, and whether any exists.
  always_comb begin
    any_free = ~&slot_busy;
    free_idx = '0;
    for (int k = NSLOT-1; k >= 0; k--) begin
      if (!slot_busy[k]) free_idx = SW'(k);
    end
  end

  // Per-requester eligibility from registered cooldown/live state.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] && enable && (cooldown[i] == '0) &&
                (live[i] < LW'(MAX_LIVE)) && any_free;
    end
  end

  // Round-robin search starting at rr_ptr; the first eligible one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int n = 0; n < NREQ; n++) begin
      int idx;
      idx = (int'(rr_ptr) + n) % NREQ;
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_idx   = OW'(idx);
      end
    end
  end

  // Next slot bitmap/owners: releases of busy slots first, then allocation.
  // The allocated slot is free pre-edge, so a release of it is a no-op.
  always_comb begin
    grant_nxt = '0;
    busy_nxt  = slot_busy & ~slot_release;
    owner_nxt = slot_owner;
    if (win_found) begin
      grant_nxt[win_idx]            = 1'b1;
      busy_nxt[free_idx]            = 1'b1;
      owner_nxt[free_idx*OW +: OW]  = win_idx;
    end
    cnt_nxt = '0;
    for (int k = 0; k < NSLOT; k++) begin
      cnt_nxt = cnt_nxt + {{(CNTW-1){1'b0}}, busy_nxt[k]};
    end
  end

  // Live counts take the net of a grant and any number of owned releases;
  // cooldown load on grant wins over a same-cycle frame decrement.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      int d;
      d = int'(live[i]);
      if (win_found && (win_idx == OW'(i))) d = d + 1;
      for (int k = 0; k < NSLOT; k++) begin
        if (slot_release[k] && slot_busy[k] && (slot_owner[k*OW +: OW] == OW'(i)))
          d = d - 1;
      end
      live_nxt[i] = LW'(d);

      cooldown_nxt[i] = cooldown[i];
      if (win_found && (win_idx == OW'(i)))
        cooldown_nxt[i] = CW'(COOLDOWN);
      else if (frame_tick && (cooldown[i] != '0))
        cooldown_nxt[i] = cooldown[i] - CW'(1);
    end
  end

  // State and registered outputs, with synchronous active-low reset.
  always_ff @(posedge clk_100mhz) begin
    if (!RSTN) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_slot  <= '0;
      slot_busy   <= '0;
      slot_owner  <= '0;
      busy_count  <= '0;
      rr_ptr      <= '0;
      for (int i = 0; i < NREQ; i++) begin
        cooldown[i] <= '0;
        live[i]     <= '0;
      end
    end else begin
      grant       <= grant_nxt;
      grant_valid <= win_found;
      if (win_found) begin
        grant_slot <= free_idx;
        rr_ptr     <= OW'((int'(win_idx) + 1) % NREQ);
      end
      slot_busy  <= busy_nxt;
      slot_owner <= owner_nxt;
      busy_count <= cnt_nxt;
      for (int i = 0; i < NREQ; i++) begin
        cooldown[i] <= cooldown_nxt[i];
        live[i]     <= live_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_bullet_arbiter.sv
// Bench for bullet_arbiter: two instances (COOLDOWN=8 and COOLDOWN=0) share
// one stimulus stream; a slot-level model checks both every cycle, and
// directed literal checks pin the expected behaviour.
module tb_bullet_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic       frame_tick;
  logic [3:0] req;
  logic [7:0] rel;

  logic [3:0]  o_grant  [2];
  logic        o_gv     [2];
  logic [2:0]  o_gslot  [2];
  logic [7:0]  o_busy   [2];
  logic [15:0] o_owner  [2];
  logic [3:0]  o_count  [2];

  int vectors    = 0;
  int miscompares = 0;
  bit checking   = 1'b0;

  // Model state per instance: slot occupancy/owner, cooldowns, rr pointer.
  logic [7:0] m_busy  [2];
  int         m_owner [2][8];
  int         m_cd    [2][4];
  int         m_rr    [2];
  logic [3:0] m_grant [2];
  logic       m_gv    [2];
  int         m_gslot [2];

  always #5 clk = ~clk;

  bullet_arbiter #(.NREQ(4), .NSLOT(8), .COOLDOWN(8), .MAX_LIVE(2)) dut_cd8 (
    .clk_100mhz(clk), .RSTN(rstn), .enable(enable), .frame_tick(frame_tick),
    .req(req), .slot_release(rel),
    .grant(o_grant[0]), .grant_valid(o_gv[0]), .grant_slot(o_gslot[0]),
    .slot_busy(o_busy[0]), .slot_owner(o_owner[0]), .busy_count(o_count[0])
  );

  bullet_arbiter #(.NREQ(4), .NSLOT(8), .COOLDOWN(0), .MAX_LIVE(2)) dut_cd0 (
    .clk_100mhz(clk), .RSTN(rstn), .enable(enable), .frame_tick(frame_tick),
    .req(req), .slot_release(rel),
    .grant(o_grant[1]), .grant_valid(o_gv[1]), .grant_slot(o_gslot[1]),
    .slot_busy(o_busy[1]), .slot_owner(o_owner[1]), .busy_count(o_count[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Live bullets of a requester = number of busy slots it owns.
  task automatic model_step(input int d, input int cdv);
    int live [4];
    int slot;
    int win;
    if (!rstn) begin
      m_busy[d] = '0;
      for (int k = 0; k < 8; k++) m_owner[d][k] = 0;
      for (int i = 0; i < 4; i++) m_cd[d][i] = 0;
      m_rr[d] = 0; m_grant[d] = '0; m_gv[d] = 1'b0; m_gslot[d] = 0;
      return;
    end
    for (int i = 0; i < 4; i++) live[i] = 0;
    for (int k = 0; k < 8; k++) if (m_busy[d][k]) live[m_owner[d][k]]++;
    slot = -1;
    for (int k = 0; k < 8; k++) if (!m_busy[d][k] && slot < 0) slot = k;
    win = -1;
    for (int n = 0; n < 4; n++) begin
      int i;
      i = (m_rr[d] + n) % 4;
      if (win < 0 && req[i] && enable && m_cd[d][i] == 0 && live[i] < 2 && slot >= 0)
        win = i;
    end
    m_busy[d] = m_busy[d] & ~rel;
    if (frame_tick) for (int i = 0; i < 4; i++) if (m_cd[d][i] > 0) m_cd[d][i]--;
    m_grant[d] = '0;
    m_gv[d]    = 1'b0;
    if (win >= 0) begin
      m_busy[d][slot]  = 1'b1;
      m_owner[d][slot] = win;
      m_cd[d][win]     = cdv;
      m_rr[d]          = (win + 1) % 4;
      m_grant[d][win]  = 1'b1;
      m_gv[d]          = 1'b1;
      m_gslot[d]       = slot;
    end
  endtask

  // Advance the model on the same edge the DUTs register.
  always @(posedge clk) begin
    model_step(0, 8);
    model_step(1, 0);
  end

  // Compare every DUT output against the model away from the clock edge.
  always @(negedge clk) begin
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        logic [15:0] eo;
        int cnt;
        eo = '0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
          eo[2*k +: 2] = 2'(m_owner[d][k]);
          if (m_busy[d][k]) cnt++;
        end
        chk($sformatf("m%0d.grant", d), 32'(o_grant[d]), 32'(m_grant[d]));
        chk($sformatf("m%0d.grant_valid", d), 32'(o_gv[d]), 32'(m_gv[d]));
        chk($sformatf("m%0d.grant_slot", d), 32'(o_gslot[d]), 32'(m_gslot[d]));
        chk($sformatf("m%0d.slot_busy", d), 32'(o_busy[d]), 32'(m_busy[d]));
        chk($sformatf("m%0d.slot_owner", d), 32'(o_owner[d]), 32'(eo));
        chk($sformatf("m%0d.busy_count", d), 32'(o_count[d]), 32'(cnt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b1; frame_tick = 1'b0; req = 4'b0001; rel = '0;
    tick();
    checking = 1'b1;
    tick();
    chk("rst.grant", 32'(o_grant[0]), 32'h0);
    chk("rst.busy", 32'(o_busy[0]), 32'h0);
    chk("rst.count", 32'(o_count[0]), 32'h0);

    // Player fires, then is held off by the 8-tick cooldown.
    rstn = 1'b1;
    tick();
    chk("p.grant", 32'(o_grant[0]), 32'h1);
    chk("p.slot", 32'(o_gslot[0]), 32'h0);
    chk("p.busy", 32'(o_busy[0]), 32'h01);
    for (int i = 0; i < 7; i++) begin
      frame_tick = 1'b1; tick();
      chk("p.cd_block", 32'(o_gv[0]), 32'h0);
      frame_tick = 1'b0; tick();
      chk("p.cd_block", 32'(o_gv[0]), 32'h0);
    end
    frame_tick = 1'b1; tick();
    chk("p.cd_last", 32'(o_gv[0]), 32'h0);
    frame_tick = 1'b0; tick();
    chk("p.regrant", 32'(o_grant[0]), 32'h1);
    chk("p.regrant_slot", 32'(o_gslot[0]), 32'h1);
    chk("p.busy2", 32'(o_busy[0]), 32'h03);
    chk("cd0.live_cap_count", 32'(o_count[1]), 32'h2);
    chk("cd0.live_cap_gv", 32'(o_gv[1]), 32'h0);

    // All four request: round-robin 0..3; COOLDOWN=0 instance fills the pool.
    rstn = 1'b0; tick();
    chk("rst2.busy", 32'(o_busy[1]), 32'h0);
    rstn = 1'b1; req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr.grant", 32'(o_grant[0]), 32'(1 << i));
      chk("rr.slot", 32'(o_gslot[0]), 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr.cd_block", 32'(o_gv[0]), 32'h0);
      chk("fill.slot", 32'(o_gslot[1]), 32'(4 + i));
    end
    chk("rr.count", 32'(o_count[0]), 32'h4);
    tick();
    chk("full.count", 32'(o_count[1]), 32'h8);
    chk("full.gv", 32'(o_gv[1]), 32'h0);
    rel = 8'h24; tick(); rel = '0;
    chk("rel24.busy", 32'(o_busy[1]), 32'hDB);
    chk("rel24.gv", 32'(o_gv[1]), 32'h0);
    tick();
    chk("after_rel.grant", 32'(o_grant[1]), 32'h2);
    chk("after_rel.slot", 32'(o_gslot[1]), 32'h2);

    // Same-cycle grant and release for requester 1: live stays at 1.
    req = 4'b0010; rel = 8'h02; tick();
    chk("net.pre_busy", 32'(o_busy[1]), 32'hDD);
    rel = 8'h04; tick();
    chk("net.grant_slot", 32'(o_gslot[1]), 32'h1);
    chk("net.busy", 32'(o_busy[1]), 32'hDB);
    rel = '0; tick();
    chk("net.second", 32'(o_grant[1]), 32'h2);
    chk("net.second_slot", 32'(o_gslot[1]), 32'h2);
    tick();
    chk("net.capped", 32'(o_gv[1]), 32'h0);

    // Releasing a free slot changes nothing.
    req = 4'b0000; rel = 8'h20; tick(); rel = '0;
    chk("freerel.busy", 32'(o_busy[1]), 32'hDF);
    chk("freerel.count", 32'(o_count[1]), 32'h7);

    // Disabled: cooldowns still drain, no grants until enabled.
    enable = 1'b0; req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1'b1; tick();
      chk("dis.gv", 32'(o_gv[0]), 32'h0);
      frame_tick = 1'b0; tick();
      chk("dis.gv", 32'(o_gv[0]), 32'h0);
    end
    enable = 1'b1; tick();
    chk("en.grant", 32'(o_grant[0]), 32'h1);
    chk("en.slot", 32'(o_gslot[0]), 32'h1);
    chk("en.busy", 32'(o_busy[0]), 32'h0B);

    // Reset while slots are busy.
    rstn = 1'b0; tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst3.busy", 32'(o_busy[d]), 32'h0);
      chk("rst3.owner", 32'(o_owner[d]), 32'h0);
      chk("rst3.count", 32'(o_count[d]), 32'h0);
      chk("rst3.gslot", 32'(o_gslot[d]), 32'h0);
      chk("rst3.gv", 32'(o_gv[d]), 32'h0);
    end
    rstn = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rstn       = ($urandom_range(0, 199) != 0);
      enable     = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      req        = 4'($urandom);
      rel        = '0;
      for (int k = 0; k < 8; k++) rel[k] = ($urandom_range(0, 7) == 0);
      tick();
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
